// File: rtl/raster_pixel_averager.sv
// rtl/raster_pixel_averager.sv - averages 2^AVG_SHIFT signed samples per pixel and hands pixels to the RAM shim
//
// Purpose: upstream stage of the raster RAM shim. Samples are summed into a
// widened accumulator; every 2^AVG_SHIFT samples the scaled sum is presented
// on o_data with o_commit held until the shim answers on i_finished. Pixels
// are counted per line and o_line_done pulses once the last pixel of a line
// has been released.
//
// Optional feature macro: RASTER_AVG_ROUND_EN
//   defined     : round half up, data = (sum + 2^(AVG_SHIFT-1)) >>> AVG_SHIFT
//   not defined : floor,         data = sum >>> AVG_SHIFT
//
// Ports:
//   i_clk          in   1        clock
//   i_rst          in   1        asynchronous active-high reset
//   i_sample       in   DAT_WID  signed ADC sample
//   i_sample_valid in   1        i_sample valid this cycle
//   i_arm          in   1        start one line (IDLE only)
//   o_data         out  DAT_WID  signed pixel value
//   o_commit       out  1        write request to the RAM shim
//   i_finished     in   1        RAM shim has completed the write
//   o_busy         out  1        high in every state except IDLE
//   o_line_done    out  1        one-cycle pulse after the last pixel of a line
//   o_dropped      out  1        sticky: sample seen in COMMIT/RELEASE
module raster_pixel_averager #(
  parameter int DAT_WID      = 24,
  parameter int AVG_SHIFT    = 2,
  parameter int PIX_CNT_WID  = 12,
  parameter int PIX_PER_LINE = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DAT_WID-1:0] i_sample,
  input  logic               i_sample_valid,
  input  logic               i_arm,
  output logic [DAT_WID-1:0] o_data,
  output logic               o_commit,
  input  logic               i_finished,
  output logic               o_busy,
  output logic               o_line_done,
  output logic               o_dropped
);

  localparam int SUM_W = DAT_WID + AVG_SHIFT;
  // Keep at least one bit so AVG_SHIFT=0 still elaborates; the counter then
  // stays at 0 and every sample is the last of its pixel.
  localparam int CNT_W = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic [PIX_CNT_WID-1:0] LINE_END = PIX_CNT_WID'(PIX_PER_LINE);
`ifdef RASTER_AVG_ROUND_EN
  // Half an LSB of the output; evaluates to 0 when AVG_SHIFT=0.
  localparam logic signed [SUM_W-1:0] RND = SUM_W'((1 << AVG_SHIFT) >> 1);
`else
  localparam logic signed [SUM_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_COMMIT  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                    r_state,     w_state_nxt;
  logic signed [SUM_W-1:0]   r_acc,       w_acc_nxt;
  logic [CNT_W-1:0]          r_smp_cnt,   w_smp_cnt_nxt;
  logic [PIX_CNT_WID-1:0]    r_pix_cnt,   w_pix_cnt_nxt;
  logic [DAT_WID-1:0]        r_data,      w_data_nxt;
  logic                      r_commit,    w_commit_nxt;
  logic                      r_line_done, w_line_done_nxt;
  logic                      r_dropped,   w_dropped_nxt;

  logic signed [SUM_W-1:0]   w_sample_ext;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SUM_W-1:0]   w_rounded;
  logic signed [SUM_W-1:0]   w_scaled;
  logic                      w_last_smp;

  // The widened accumulator cannot overflow over 2^AVG_SHIFT samples, and
  // adding RND to a full-scale sum still fits, so no saturation is needed.
  assign w_sample_ext = SUM_W'($signed(i_sample));
  assign w_sum        = r_acc + w_sample_ext;
  assign w_rounded    = w_sum + RND;
  assign w_scaled     = w_rounded >>> AVG_SHIFT;
  assign w_last_smp   = (r_smp_cnt == LAST_CNT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_smp_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_data      <= '0;
      r_commit    <= 1'b0;
      r_line_done <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_smp_cnt   <= w_smp_cnt_nxt;
      r_pix_cnt   <= w_pix_cnt_nxt;
      r_data      <= w_data_nxt;
      r_commit    <= w_commit_nxt;
      r_line_done <= w_line_done_nxt;
      r_dropped   <= w_dropped_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_smp_cnt_nxt   = r_smp_cnt;
    w_pix_cnt_nxt   = r_pix_cnt;
    w_data_nxt      = r_data;
    w_commit_nxt    = r_commit;
    w_line_done_nxt = 1'b0;
    w_dropped_nxt   = r_dropped;

    case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_acc_nxt     = '0;
          w_smp_cnt_nxt = '0;
          w_pix_cnt_nxt = '0;
          w_dropped_nxt = 1'b0;
          w_state_nxt   = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (i_sample_valid) begin
          if (w_last_smp) begin
            w_data_nxt    = w_scaled[DAT_WID-1:0];
            w_commit_nxt  = 1'b1;
            w_acc_nxt     = '0;
            w_smp_cnt_nxt = '0;
            w_state_nxt   = S_COMMIT;
          end else begin
            w_acc_nxt     = w_sum;
            w_smp_cnt_nxt = r_smp_cnt + 1'b1;
          end
        end
      end

      S_COMMIT: begin
        if (i_sample_valid) begin
          w_dropped_nxt = 1'b1;
        end
        if (i_finished) begin
          w_commit_nxt  = 1'b0;
          w_pix_cnt_nxt = r_pix_cnt + 1'b1;
          w_state_nxt   = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // A sample on the edge that leaves RELEASE is still a drop.
        if (i_sample_valid) begin
          w_dropped_nxt = 1'b1;
        end
        if (!i_finished) begin
          if (r_pix_cnt == LINE_END) begin
            w_line_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt     = S_ACCUM;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_data      = r_data;
  assign o_commit    = r_commit;
  assign o_busy      = (r_state != S_IDLE);
  assign o_line_done = r_line_done;
  assign o_dropped   = r_dropped;

endmodule

// File: tb/tb_raster_pixel_averager.sv
// tb/tb_raster_pixel_averager.sv - self-checking bench for raster_pixel_averager
module tb_raster_pixel_averager;

  localparam int DW  = 24;
  localparam int PPL = 3;

`ifdef RASTER_AVG_ROUND_EN
  localparam int NEG_EXP = -1;
  localparam int ODD_EXP = 3;
`else
  localparam int NEG_EXP = -2;
  localparam int ODD_EXP = 2;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_sample = '0;
  logic          i_sample_valid = 1'b0;
  logic          i_arm = 1'b0;
  logic          i_finished = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_commit;
  logic          o_busy;
  logic          o_line_done;
  logic          o_dropped;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_pix = 0;
  int ld_count = 0;
  bit prev_commit = 1'b0;
  bit prev_ld = 1'b0;

  raster_pixel_averager #(
    .DAT_WID(DW), .AVG_SHIFT(2), .PIX_CNT_WID(12), .PIX_PER_LINE(PPL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample),
    .i_sample_valid(i_sample_valid), .i_arm(i_arm), .o_data(o_data),
    .o_commit(o_commit), .i_finished(i_finished), .o_busy(o_busy),
    .o_line_done(o_line_done), .o_dropped(o_dropped)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mean of four samples as a mathematical floor division (or round half up).
  function automatic int exp_pix(input int a, input int b, input int c, input int d);
    longint s;
    s = longint'(a) + b + c + d;
`ifdef RASTER_AVG_ROUND_EN
    s = s + 2;
`endif
    if (s >= 0) return int'(s / 4);
    return int'(-((-s + 3) / 4));
  endfunction

  // Compare process: every held commit must present the pixel the model
  // expects; line_done must only follow the last pixel of a line.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_commit = 1'b0;
      prev_ld     = 1'b0;
      model_pix   = 0;
      exp_q.delete();
    end else begin
      if (o_commit) begin
        check("commit_has_model", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("data_vs_model", int'($signed(o_data)), exp_q[0]);
      end
      if (prev_commit && !o_commit) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_pix++;
      end
      if (o_line_done) begin
        ld_count++;
        check("line_done_at_line_end", int'(model_pix != 0 && model_pix % PPL == 0), 1);
        check("line_done_one_cycle", int'(prev_ld), 0);
      end
      prev_commit = o_commit;
      prev_ld     = o_line_done;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    check("busy_after_arm", int'(o_busy), 1);
  endtask

  // Four back-to-back samples; optionally an ignored arm after the first.
  task automatic send_pixel(input int a, input int b, input int c, input int d, input bit arm_mid);
    int v[4];
    v = '{a, b, c, d};
    exp_q.push_back(exp_pix(a, b, c, d));
    for (int i = 0; i < 4; i++) begin
      i_sample = DW'(v[i]);
      i_sample_valid = 1'b1;
      tick();
      i_sample_valid = 1'b0;
      if (arm_mid && i == 0) begin
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
      end
    end
    check("commit_latency", int'(o_commit), 1);
  endtask

  task automatic handshake(input int hold, output int n);
    repeat (hold) tick();
    i_finished = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_commit && n < 20);
    check("commit_fall", int'(o_commit), 0);
    i_finished = 1'b0;
    tick();
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (!o_commit && n < 40) begin
      tick();
      n++;
    end
    check("commit_seen", int'(o_commit), 1);
  endtask

  initial begin
    int n;
    int ld_before;

    // Reset state
    tick();
    check("rst_data", int'(o_data), 0);
    check("rst_commit", int'(o_commit), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_line_done", int'(o_line_done), 0);
    check("rst_dropped", int'(o_dropped), 0);
    i_rst = 1'b0;
    tick();

    // Pin the model with hand-computed values
    check("model_basic", exp_pix(4, 8, 12, 16), 10);
    check("model_neg", exp_pix(-1, -1, -1, -2), NEG_EXP);
    check("model_odd", exp_pix(1, 2, 3, 5), ODD_EXP);

    // Line 1: basic average, negative values, positive full scale
    do_arm();
    send_pixel(4, 8, 12, 16, 1'b0);
    check("basic_data", int'($signed(o_data)), 10);
    handshake(0, n);
    check("release_latency", n, 1);
    check("mid_line_no_done", int'(o_line_done), 0);
    check("mid_line_busy", int'(o_busy), 1);
    send_pixel(-1, -1, -1, -2, 1'b0);
    check("neg_data", int'($signed(o_data)), NEG_EXP);
    handshake(2, n);
    send_pixel(8388607, 8388607, 8388607, 8388607, 1'b0);
    check("fs_pos_data", int'(o_data), 32'h7FFFFF);
    handshake(1, n);
    check("line1_done", int'(o_line_done), 1);
    check("line1_idle", int'(o_busy), 0);
    tick();
    check("line1_done_clear", int'(o_line_done), 0);

    // Line 2: negative full scale, ignored arm mid-pixel, odd sum
    do_arm();
    send_pixel(-8388608, -8388608, -8388608, -8388608, 1'b0);
    check("fs_neg_data", int'(o_data), 32'h800000);
    handshake(0, n);
    send_pixel(100, 200, 300, 400, 1'b1);
    check("ignored_arm_data", int'($signed(o_data)), 250);
    handshake(3, n);
    send_pixel(1, 2, 3, 5, 1'b0);
    check("odd_data", int'($signed(o_data)), ODD_EXP);
    handshake(0, n);
    check("line2_done", int'(o_line_done), 1);
    check("line2_no_drop", int'(o_dropped), 0);

    // Line 3: continuous samples with a slow RAM shim
    tick();
    ld_before = ld_count;
    do_arm();
    i_sample = DW'(7);
    i_sample_valid = 1'b1;
    for (int p = 0; p < PPL; p++) begin
      exp_q.push_back(7);
      wait_commit();
      handshake(5, n);
    end
    check("drop_line_done", int'(o_line_done), 1);
    check("drop_idle", int'(o_busy), 0);
    repeat (3) tick();
    i_sample_valid = 1'b0;
    check("dropped_set", int'(o_dropped), 1);
    check("drop_one_line_done", ld_count - ld_before, 1);
    do_arm();
    check("dropped_cleared", int'(o_dropped), 0);

    // Asynchronous reset while committing
    send_pixel(9, 9, 9, 9, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_commit_drop", int'(o_commit), 0);
    check("async_busy_drop", int'(o_busy), 0);
    tick();
    i_rst = 1'b0;
    i_sample = DW'(5);
    i_sample_valid = 1'b1;
    repeat (4) tick();
    i_sample_valid = 1'b0;
    tick();
    check("post_rst_no_commit", int'(o_commit), 0);
    check("post_rst_idle", int'(o_busy), 0);
    do_arm();
    send_pixel(20, 20, 20, 20, 1'b0);
    check("post_rst_data", int'($signed(o_data)), 20);
    handshake(0, n);
    send_pixel(-3, -3, -3, -3, 1'b0);
    handshake(0, n);
    send_pixel(0, 0, 0, 1, 1'b0);
    check("tiny_data", int'($signed(o_data)), 0);
    handshake(0, n);
    check("line4_done", int'(o_line_done), 1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
